// File: rtl/step_ctrl.sv
// Single-step / free-run / breakpoint controller producing a processor clock enable.
// Button path: 2-flop sync + DB_CYCLES debounce + 1-cycle step pulse; cpu_en is a same-cycle decode.
module step_ctrl #(
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn0,
   input  logic             run,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      PC,
   output logic             cpu_en,
   output logic             halted,
   output logic             bp_hit,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] en_cnt
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      HALT = 2'd0,
      STEP = 2'd1,
      RUN  = 2'd2,
      BRK  = 2'd3
   } stateT;

   stateT          curState;
   stateT          nextState;
   logic           sync0;
   logic           sync1;
   logic           db;
   logic           stepP;
   logic           firstRun;
   logic           bpMatch;
   logic [DBW-1:0] dbCnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= btn0;
         sync1 <= sync0;
      end
   end

   // stepP is raised on the same edge db rises, so it lasts exactly one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db    <= 1'b0;
         dbCnt <= '0;
         stepP <= 1'b0;
      end else begin
         stepP <= 1'b0;
         if (sync1 == db) begin
            dbCnt <= '0;
         end else if (dbCnt == DB_LAST) begin
            db    <= sync1;
            dbCnt <= '0;
            stepP <= sync1;
         end else begin
            dbCnt <= dbCnt + DBW'(1);
         end
      end
   end

   // Masked in the first RUN cycle so resuming at the breakpoint PC moves past it
   assign bpMatch = bp_en && (PC == bp_addr) && !firstRun;

   always_comb begin
      nextState = curState;
      cpu_en    = 1'b0;
      case (curState)
         HALT: begin
            if (run)        nextState = RUN;
            else if (stepP) nextState = STEP;
         end
         STEP: begin
            cpu_en    = 1'b1;
            nextState = HALT;
         end
         RUN: begin
            if (!run)         nextState = HALT;
            else if (bpMatch) nextState = BRK;
            else              cpu_en    = 1'b1;
         end
         BRK: begin
            if (!run)       nextState = HALT;
            else if (stepP) nextState = STEP;
         end
         default: nextState = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         curState <= HALT;
         halted   <= 1'b1;
         bp_hit   <= 1'b0;
         firstRun <= 1'b0;
         en_cnt   <= '0;
      end else begin
         curState <= nextState;
         halted   <= (nextState == HALT) || (nextState == BRK);
         bp_hit   <= (nextState == BRK);
         firstRun <= (nextState == RUN) && (curState != RUN);
         if (cpu_en) en_cnt <= en_cnt + CNT_W'(1);
      end
   end

   assign state = curState;

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_step_ctrl;

   localparam int DB   = 4;
   localparam int CW   = 4;
   localparam int CMOD = 1 << CW;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn0;
   logic          run;
   logic          bp_en;
   logic [31:0]   bp_addr;
   logic [31:0]   PC;
   logic          cpu_en;
   logic          halted;
   logic          bp_hit;
   logic [1:0]    state;
   logic [CW-1:0] en_cnt;

   step_ctrl #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .btn0(btn0), .run(run), .bp_en(bp_en),
      .bp_addr(bp_addr), .PC(PC), .cpu_en(cpu_en), .halted(halted),
      .bp_hit(bp_hit), .state(state), .en_cnt(en_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int stepSeen = 0;
   int enSeen = 0;

   // reference model: mode 0=HALT 1=STEP 2=RUN 3=BRK
   int          mState;
   bit          mFirst;
   bit          mDb;
   bit          mStep;
   int          mCnt;
   logic [31:0] mPc = 32'h0;
   logic        btnQ[$];
   logic        dbQ[$];

   task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit expMatch();
      return bp_en && (PC == bp_addr) && !mFirst;
   endfunction

   function automatic bit expEn();
      return (mState == 1) || (mState == 2 && run && !expMatch());
   endfunction

   task automatic modelReset();
      mState = 0; mFirst = 0; mDb = 0; mStep = 0; mCnt = 0;
      btnQ = '{1'b0, 1'b0};
      dbQ.delete();
   endtask

   task automatic modelEdge();
      bit   en;
      int   nxt;
      logic dbIn;
      en = expEn();
      case (mState)
         0: nxt = run ? 2 : (mStep ? 1 : 0);
         1: nxt = 0;
         2: nxt = !run ? 0 : (expMatch() ? 3 : 2);
         default: nxt = !run ? 0 : (mStep ? 1 : 3);
      endcase
      mFirst = (nxt == 2) && (mState != 2);
      mState = nxt;
      if (en) begin
         mCnt = (mCnt + 1) % CMOD;
         mPc  = (mPc + 32'd4) & 32'h3F;
      end
      // button seen by the debouncer is the sample from two edges ago
      dbIn = btnQ[btnQ.size() - 2];
      btnQ.push_back(btn0);
      if (btnQ.size() > 3) void'(btnQ.pop_front());
      mStep = 0;
      if (dbIn == mDb) dbQ.delete();
      else begin
         dbQ.push_back(dbIn);
         if (dbQ.size() == DB) begin
            mStep = !mDb;
            mDb   = dbIn;
            dbQ.delete();
         end
      end
   endtask

   task automatic doCycle();
      @(negedge clk);
      chkVal("cpu_en", cpu_en, expEn());
      chkVal("state", state, mState);
      chkVal("halted", halted, (mState == 0 || mState == 3));
      chkVal("bp_hit", bp_hit, (mState == 3));
      chkVal("en_cnt", en_cnt, mCnt);
      if (state == 2'd1) stepSeen++;
      if (cpu_en) enSeen++;
      @(posedge clk);
      modelEdge();
      #1;
      PC = mPc;
   endtask

   task automatic drive(input logic b, input logic r, input logic be,
                        input logic [31:0] ba, input int n);
      btn0 = b; run = r; bp_en = be; bp_addr = ba;
      for (int k = 0; k < n; k++) doCycle();
   endtask

   task automatic doReset();
      #2 reset = 1'b0;
      #1;
      chkVal("rst_cpu_en", cpu_en, 0);
      chkVal("rst_en_cnt", en_cnt, 0);
      chkVal("rst_state", state, 0);
      chkVal("rst_halted", halted, 1);
      chkVal("rst_bp_hit", bp_hit, 0);
      modelReset();
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      logic        rb, rr, rbe;
      logic [31:0] rba;
      int          hold;
      bit          found;
      reset = 1'b0; btn0 = 0; run = 0; bp_en = 0; bp_addr = 0; PC = 0;
      #12;
      chkVal("init_state", state, 0);
      chkVal("init_cpu_en", cpu_en, 0);
      chkVal("init_halted", halted, 1);
      chkVal("init_bp_hit", bp_hit, 0);
      chkVal("init_en_cnt", en_cnt, 0);
      modelReset();
      @(posedge clk); #2 reset = 1'b1;

      // held press gives exactly one step
      stepSeen = 0; enSeen = 0;
      drive(1, 0, 0, 0, 10);
      chkVal("r030_steps", stepSeen, 1);
      chkVal("r030_en", enSeen, 1);
      chkVal("r030_cnt", en_cnt, 1);
      chkVal("r030_state", state, 0);
      drive(0, 0, 0, 0, 10);

      // bounce shorter than the debounce window
      doReset();
      stepSeen = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 0, 0, 2);
         drive(0, 0, 0, 0, 2);
      end
      drive(0, 0, 0, 0, 8);
      chkVal("r031_steps", stepSeen, 0);
      chkVal("r031_cnt", en_cnt, 0);

      // free run into breakpoint at 0x10
      doReset();
      mPc = 0; PC = 0;
      drive(0, 1, 1, 32'h10, 7);
      chkVal("r032_state", state, 3);
      chkVal("r032_bphit", bp_hit, 1);
      chkVal("r032_cnt", en_cnt, 4);
      chkVal("r032_pc", PC, 32'h10);
      chkVal("r032_en", cpu_en, 0);

      // step out of BRK with run held, then resume running
      stepSeen = 0;
      drive(1, 1, 1, 32'h10, 12);
      chkVal("r033_steps", stepSeen, 1);
      chkVal("r033_state", state, 2);
      drive(0, 1, 1, 32'h10, 6);

      // resume at the breakpoint PC is not re-hit on the first RUN cycle
      doReset();
      mPc = 0; PC = 0;
      drive(0, 1, 1, 32'h10, 7);
      drive(0, 0, 1, 32'h10, 1);
      drive(0, 1, 1, 32'h10, 1);
      #2;
      chkVal("r033_supp_pc", PC, 32'h10);
      chkVal("r033_supp_en", cpu_en, 1);
      drive(0, 1, 1, 32'h10, 3);
      chkVal("r033_supp_state", state, 2);

      // run wins over a simultaneous step pulse in HALT
      doReset();
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (mStep) found = 1;
         else drive(1, 0, 0, 0, 1);
      end
      chkVal("r034_pulse_seen", found, 1);
      stepSeen = 0;
      drive(1, 1, 0, 0, 1);
      chkVal("r034_state", state, 2);
      drive(1, 1, 0, 0, 3);
      chkVal("r034_steps", stepSeen, 0);
      drive(0, 0, 0, 0, 8);

      // counter wrap then asynchronous reset mid-run
      doReset();
      drive(0, 1, 0, 0, 18);
      chkVal("r035_wrap", en_cnt, 1);
      chkVal("r035_run_en", cpu_en, 1);
      doReset();

      // reset mid-debounce, button kept held
      drive(1, 0, 0, 0, 4);
      doReset();
      stepSeen = 0;
      drive(1, 0, 0, 0, 14);
      drive(0, 0, 0, 0, 8);
      chkVal("r029_steps", stepSeen, 1);

      // random traffic
      rb = 0; rr = 0; rbe = 0; rba = 32'h10; hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            rb   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
         end
         hold--;
         if ($urandom_range(0, 15) == 0) rr = ~rr;
         if ($urandom_range(0, 31) == 0) rbe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0)
            rba = ($urandom_range(0, 7) == 0) ? 32'h1000_0010 : 32'($urandom_range(0, 15)) * 32'd4;
         if ($urandom_range(0, 99) == 0) begin
            mPc = 32'($urandom_range(0, 15)) * 32'd4;
            PC  = mPc;
         end
         if ($urandom_range(0, 499) == 0) doReset();
         drive(rb, rr, rbe, rba, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
